// File: rtl/data_sram_responder_pkg.sv
// Shared constants, register selects and helpers for the data_sram responder.
// MMIO offsets are relative to the window selected by addr[31:16].
package data_sram_responder_pkg;

    localparam logic [15:0] MMIO_LED_OFF   = 16'hF000;
    localparam logic [15:0] MMIO_NUM_OFF   = 16'hF004;
    localparam logic [15:0] MMIO_SW_OFF    = 16'hF008;
    localparam logic [15:0] MMIO_TIMER_OFF = 16'hE000;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_NUM,
        REG_SW,
        REG_TIMER
    } mmio_reg_e;

    // Where the registered read response comes from; ZERO is the post-reset state.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_RAM,
        SRC_MMIO
    } rd_src_e;

    function automatic mmio_reg_e decode_off(input logic [15:0] off);
        mmio_reg_e sel;
        case (off)
            MMIO_LED_OFF:   sel = REG_LED;
            MMIO_NUM_OFF:   sel = REG_NUM;
            MMIO_SW_OFF:    sel = REG_SW;
            MMIO_TIMER_OFF: sel = REG_TIMER;
            default:        sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_be_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents and read register are intentionally not reset.
module sram_be_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Slave side of the core's data_sram port: byte-writable RAM plus an MMIO window
// (LED, NUM, SWITCH, TIMER) with a one-cycle read response.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF,
    parameter bit          TIMER_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    logic        mmio_hit;
    mmio_reg_e   reg_sel;
    logic        rd_req;
    logic        wr_req;
    logic        ram_en;
    logic [31:0] ram_rdata;

    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] timer_q;
    logic [7:0]  sw_s1;
    logic [7:0]  sw_s2;

    logic [31:0] led_merge;
    logic [31:0] num_merge;
    logic [31:0] timer_merge;
    logic [31:0] mmio_rd_val;

    rd_src_e     rd_src_p1;
    logic [31:0] mmio_rd_p1;

    // ---- request stage (p0): decode ----
    assign mmio_hit = (sram_addr[31:16] == MMIO_BASE);
    assign reg_sel  = decode_off(sram_addr[15:0]);
    assign rd_req   = sram_en && (sram_wen == 4'b0000);
    assign wr_req   = sram_en && (sram_wen != 4'b0000);
    assign ram_en   = sram_en && !mmio_hit;

    sram_be_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (sram_wen),
        .addr  (sram_addr[ADDR_W+1:2]),
        .wdata (sram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        // LED is 16 bits wide, so lanes 2/3 are masked off before merging.
        led_merge   = byte_merge({16'h0000, led_q}, sram_wdata, {2'b00, sram_wen[1:0]});
        num_merge   = byte_merge(num_q, sram_wdata, sram_wen);
        timer_merge = byte_merge(timer_q, sram_wdata, sram_wen);
    end

    always_comb begin
        mmio_rd_val = 32'h0000_0000;
        case (reg_sel)
            REG_LED:   mmio_rd_val = {16'h0000, led_q};
            REG_NUM:   mmio_rd_val = num_q;
            REG_SW:    mmio_rd_val = {24'h000000, sw_s2};
            REG_TIMER: mmio_rd_val = timer_q;
            default:   mmio_rd_val = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= 16'h0000;
            num_q <= 32'h0000_0000;
        end else if (wr_req && mmio_hit) begin
            if (reg_sel == REG_LED) led_q <= led_merge[15:0];
            if (reg_sel == REG_NUM) num_q <= num_merge;
        end
    end

    // A write in the same cycle as an increment wins; counting resumes from it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 32'h0000_0000;
        end else if (wr_req && mmio_hit && (reg_sel == REG_TIMER)) begin
            timer_q <= timer_merge;
        end else if (TIMER_EN) begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1 <= 8'h00;
            sw_s2 <= 8'h00;
        end else begin
            sw_s1 <= switch_in;
            sw_s2 <= sw_s1;
        end
    end

    // ---- response stage (p1): source and MMIO value captured only on reads ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_src_p1  <= SRC_ZERO;
            mmio_rd_p1 <= 32'h0000_0000;
        end else if (rd_req) begin
            rd_src_p1  <= mmio_hit ? SRC_MMIO : SRC_RAM;
            mmio_rd_p1 <= mmio_rd_val;
        end
    end

    always_comb begin
        sram_rdata = 32'h0000_0000;
        case (rd_src_p1)
            SRC_RAM:  sram_rdata = ram_rdata;
            SRC_MMIO: sram_rdata = mmio_rd_p1;
            default:  sram_rdata = 32'h0000_0000;
        endcase
    end

    assign led_out = led_q;
    assign num_out = num_q;

endmodule
